// File: rtl/hall_turn_tracker.sv
// Hall-sensor turn tracker: synchronise/debounce hall_n, measure turn period, interpolate angle.
// Optional HALL_TURN_STATS_EN adds a 16-bit wrapping turn_count output.
module hall_turn_tracker #(
  parameter int unsigned     NB_ANGLES       = 128,
  parameter int unsigned     PERIOD_WIDTH    = 32,
  parameter int unsigned     DEBOUNCE_CYCLES = 1024,
  parameter longint unsigned MAX_PERIOD      = 64'd1 << (PERIOD_WIDTH - 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         hall_n,
  output logic                         turn_tick,
  output logic                         angle_tick,
  output logic [$clog2(NB_ANGLES)-1:0] angle,
  output logic [PERIOD_WIDTH-1:0]      period,
  output logic                         period_valid
`ifdef HALL_TURN_STATS_EN
  ,
  output logic [15:0]                  turn_count
`endif
);

  localparam int unsigned AW = $clog2(NB_ANGLES);
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0]           DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PERIOD_WIDTH-1:0] TIMEOUT_AT = PERIOD_WIDTH'(MAX_PERIOD - 64'd1);
  localparam logic [AW-1:0]           ANGLE_MAX  = AW'(NB_ANGLES - 1);
  localparam logic [PERIOD_WIDTH:0]   ANGLE_STEP = (PERIOD_WIDTH + 1)'(NB_ANGLES);

  typedef enum logic [1:0] {IDLE, MEASURE, RUN} state_t;

  logic [1:0]              sync_q;
  logic [1:0]              warm_q, warm_d;
  logic                    armed_q, armed_d;
  logic                    deb_q, deb_d, deb_dly_q;
  logic [DW-1:0]           deb_cnt_q, deb_cnt_d;
  logic                    turn_tick_q, turn_tick_d;
  state_t                  state_q, state_d;
  logic [PERIOD_WIDTH-1:0] pcnt_q, pcnt_d;
  logic [PERIOD_WIDTH-1:0] period_q, period_d;
  logic                    valid_q, valid_d;
  logic [PERIOD_WIDTH:0]   acc_q, acc_d, sum;
  logic [AW-1:0]           angle_q, angle_d;
  logic                    atick_q, atick_d;
  logic                    timeout;

  // A turn is armed only once a genuine high level has been seen after reset,
  // so a sensor already held low at reset release cannot produce a turn_tick.
  always_comb begin
    warm_d      = {warm_q[0], 1'b1};
    armed_d     = armed_q | (warm_q[1] & sync_q[1]);
    deb_d       = deb_q;
    deb_cnt_d   = '0;
    if (sync_q[1] != deb_q) begin
      if (deb_cnt_q == DEB_LAST) deb_d = sync_q[1];
      else                       deb_cnt_d = deb_cnt_q + 1'b1;
    end
    turn_tick_d = armed_q & deb_dly_q & ~deb_q;
  end

  always_comb begin
    timeout  = (pcnt_q >= TIMEOUT_AT);
    state_d  = state_q;
    pcnt_d   = timeout ? pcnt_q : pcnt_q + 1'b1;
    period_d = period_q;
    valid_d  = valid_q;
    acc_d    = acc_q;
    angle_d  = angle_q;
    atick_d  = 1'b0;
    sum      = acc_q + ANGLE_STEP;
    if (turn_tick_q) begin
      pcnt_d  = PERIOD_WIDTH'(1);
      acc_d   = '0;
      angle_d = '0;
      if (state_q == IDLE) begin
        state_d = MEASURE;
      end else begin
        state_d  = RUN;
        period_d = pcnt_q;
        valid_d  = 1'b1;
      end
    end else if (timeout) begin
      state_d  = IDLE;
      period_d = '0;
      valid_d  = 1'b0;
      acc_d    = '0;
      angle_d  = '0;
    end else if (state_q == RUN && angle_q != ANGLE_MAX) begin
      // Keeping the remainder makes the slot count exact: floor(NB_ANGLES*k/period).
      if (sum >= {1'b0, period_q}) begin
        acc_d   = sum - {1'b0, period_q};
        angle_d = angle_q + 1'b1;
        atick_d = 1'b1;
      end else begin
        acc_d = sum;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= 2'b11;
      warm_q      <= '0;
      armed_q     <= 1'b0;
      deb_q       <= 1'b1;
      deb_dly_q   <= 1'b1;
      deb_cnt_q   <= '0;
      turn_tick_q <= 1'b0;
      state_q     <= IDLE;
      pcnt_q      <= '0;
      period_q    <= '0;
      valid_q     <= 1'b0;
      acc_q       <= '0;
      angle_q     <= '0;
      atick_q     <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], hall_n};
      warm_q      <= warm_d;
      armed_q     <= armed_d;
      deb_q       <= deb_d;
      deb_dly_q   <= deb_q;
      deb_cnt_q   <= deb_cnt_d;
      turn_tick_q <= turn_tick_d;
      state_q     <= state_d;
      pcnt_q      <= pcnt_d;
      period_q    <= period_d;
      valid_q     <= valid_d;
      acc_q       <= acc_d;
      angle_q     <= angle_d;
      atick_q     <= atick_d;
    end
  end

`ifdef HALL_TURN_STATS_EN
  logic [15:0] turn_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              turn_count_q <= '0;
    else if (turn_tick_q) turn_count_q <= turn_count_q + 16'd1;
  end

  assign turn_count = turn_count_q;
`endif

  assign turn_tick    = turn_tick_q;
  assign angle_tick   = atick_q;
  assign angle        = angle_q;
  assign period       = period_q;
  assign period_valid = valid_q;

endmodule

// File: doc/hall_turn_tracker.md
HALL_TURN_TRACKER -- requirements
Module: hall_turn_tracker

Interface
REQ-001 SHALL have parameter NB_ANGLES, default 128: angular slots per turn, power of two, at least 2.
REQ-002 SHALL have parameter PERIOD_WIDTH, default 32: width of the turn-period counter, in clk cycles.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 1024: number of consecutive stable samples needed to accept a hall level change.
REQ-004 SHALL have parameter MAX_PERIOD, default 2**(PERIOD_WIDTH-1): stall timeout, in clk cycles.
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port hall_n, input, 1 bit: raw hall sensor, asynchronous to clk, active low.
REQ-008 SHALL have port turn_tick, output, 1 bit: one-cycle pulse per detected turn; feeds the synchronizer.
REQ-009 SHALL have port angle_tick, output, 1 bit: one-cycle pulse on each angular slot advance.
REQ-010 SHALL have port angle, output, $clog2(NB_ANGLES) bits: current angular slot.
REQ-011 SHALL have port period, output, PERIOD_WIDTH bits: last measured turn period, in clk cycles.
REQ-012 SHALL have port period_valid, output, 1 bit: period holds a valid measurement and angle ticks are running.

Function
REQ-013 SHALL pass hall_n through a two-flop synchronizer before any other use.
REQ-014 SHALL update the debounced level only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles; any return to the current debounced level clears the count.
REQ-015 SHALL pulse turn_tick for exactly one cycle on each debounced 1->0 transition; latency from a settled hall_n fall to turn_tick high is DEBOUNCE_CYCLES+3 cycles.
REQ-016 SHALL implement states IDLE, MEASURE and RUN: IDLE->MEASURE on turn_tick; MEASURE->RUN on turn_tick; RUN->RUN on turn_tick.
REQ-017 SHALL count cycles between consecutive turn_ticks (pulses N cycles apart give period=N), latching period on the second and each later tick; on the MEASURE->RUN tick it SHALL also set period_valid=1.
REQ-018 SHALL, in any state, go to IDLE, clear period and period_valid, and zero angle once the cycle count since the last turn_tick reaches MAX_PERIOD; the count SHALL saturate and never wrap.
REQ-019 SHALL, in RUN, add NB_ANGLES each cycle to an accumulator of PERIOD_WIDTH+1 bits.
REQ-020 SHALL, when the sum reaches at least period, pulse angle_tick, increment angle, and keep sum minus period; the accumulator therefore has no cumulative drift.
REQ-021 SHALL hold angle at NB_ANGLES-1 when the rotor slows, emitting no angle_tick and no wrap, until the next turn_tick.
REQ-022 SHALL, on every turn_tick, set angle=0 and clear the accumulator in the same cycle; a coincident angle_tick is suppressed (turn_tick wins).
REQ-023 SHALL never emit angle_tick in IDLE or MEASURE, where angle stays 0.

Reset
REQ-024 SHALL, while rst=1, asynchronously force state IDLE, turn_tick=0, angle_tick=0, angle=0, period=0, period_valid=0, counters and accumulator 0, synchronizer flops 1, and debounced level 1.
REQ-025 SHALL NOT produce a turn_tick after reset release while hall_n is already held low; a high-then-low transition is required first.

Configuration
REQ-026 SHALL, with macro HALL_TURN_STATS_EN defined, add output turn_count (16 bits, reset 0) that increments on each turn_tick and wraps from 65535 to 0.
REQ-027 SHALL, without HALL_TURN_STATS_EN, have neither the turn_count port nor its logic, with all other behaviour identical.

Verification
REQ-028 SHALL cover: DEBOUNCE_CYCLES=4, hall_n falls and stays low -> single turn_tick 7 cycles later; a 3-cycle low glitch -> no turn_tick.
REQ-029 SHALL cover: NB_ANGLES=128, turn_ticks 1280 cycles apart x3 -> period=1280, period_valid=1 after the 2nd tick; in turn 3, angle_tick every 10 cycles, angle 1..127, angle=0 at each tick.
REQ-030 SHALL cover: period 1280, then a turn lasting 1400 -> angle holds at 127 from cycle 1270 to 1400, no extra angle_tick.
REQ-031 SHALL cover: MAX_PERIOD=2000, ticks stop after RUN -> 2000 cycles after the last tick: period_valid=0, period=0, angle=0; the next tick enters MEASURE with no angle_ticks.
REQ-032 SHALL cover: rst asserted mid-RUN with hall_n held low -> all outputs 0 immediately; after release, no turn_tick until hall_n goes high then low.
REQ-033 SHALL cover: with HALL_TURN_STATS_EN defined, 65537 turn_ticks -> turn_count=1.
